clk_mux_ctrl: RTL and testbench

Reference-clock-domain controller that issues clock-select changes to the glitch-free clock mux and reports when each change has settled. It accepts switch requests over a valid/ready handshake and drives the mux select from a register. It then holds off further requests for a programmed settle window that covers the mux's per-clock synchronizer hand-off, and pulses a completion strobe when the window ends. It sits in the clock/reset controller, on an always-running reference clock, upstream of the mux's select input.

---
 rtl/clk_mux_ctrl_pkg.sv | 19 +
 rtl/clk_mux_ctrl_cnt.sv | 28 ++
 rtl/clk_mux_ctrl.sv | 97 +++++++++
 tb/tb_clk_mux_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clk_mux_ctrl_pkg.sv
// Shared types and constants for the clock-mux select controller.
// State encoding, default settle window and parameter legality check.
package clk_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 8;

  // The settle window must be non-empty and fit the counter.
  function automatic bit settle_cycles_ok(int unsigned settle, int unsigned cnt_w);
    return (settle >= 1) && (cnt_w >= 1) && (cnt_w < 32) &&
           (64'(settle) < (64'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/clk_mux_ctrl_cnt.sv
// Loadable down-counter for the settle window: load, decrement-if-nonzero,
// zero flag. Decrementing only when nonzero means it never wraps.
module clk_mux_ctrl_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_mux_ctrl.sv
// Reference-clock controller that drives the glitch-free clock mux select
// and reports when each change has settled. Optional macro CLK_MUX_CTRL_LOCK_EN
// adds lock_i, which blocks new requests without aborting one in flight.
module clk_mux_ctrl
  import clk_mux_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W         = 8,
  parameter logic        RESET_SEL     = 1'b0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
`ifdef CLK_MUX_CTRL_LOCK_EN
  input  logic   lock_i,
`endif
  input  logic   req_valid_i,
  input  logic   req_sel_i,
  output logic   req_ready_o,
  output logic   sel_o,
  output logic   busy_o,
  output logic   done_o,
  output state_e dbg_state_o
);

  if (!settle_cycles_ok(SETTLE_CYCLES, CNT_W)) begin : g_bad_settle
    $error("clk_mux_ctrl: SETTLE_CYCLES must satisfy 1 <= SETTLE_CYCLES < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic   sel_q;
  logic   cnt_zero;
  logic   accept;
  logic   idle;

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; the requester holds req_valid_i/req_sel_i
  // stable until then. req_ready_o depends only on state, reset and lock.
  assign idle = (state_q == ST_IDLE);
`ifdef CLK_MUX_CTRL_LOCK_EN
  assign req_ready_o = idle & ~lock_i & rst_ni;
`else
  assign req_ready_o = idle & rst_ni;
`endif
  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= RESET_SEL;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q <= req_sel_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_zero) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      ST_SETTLE: busy_o = 1'b1;
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  clk_mux_ctrl_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_val_i (LOAD_VAL),
    .dec_i      (state_q == ST_SETTLE),
    .zero_o     (cnt_zero)
  );

  assign sel_o       = sel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_mux_ctrl.sv
// Directed self-checking bench for clk_mux_ctrl (SETTLE_CYCLES=8, RESET_SEL=0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clk_mux_ctrl;
  import clk_mux_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   req_valid;
  logic   req_sel;
  logic   req_ready;
  logic   sel;
  logic   busy;
  logic   done;
  state_e dbg_state;
`ifdef CLK_MUX_CTRL_LOCK_EN
  logic   lock;
`endif

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  clk_mux_ctrl #(
    .SETTLE_CYCLES(8),
    .CNT_W        (8),
    .RESET_SEL    (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef CLK_MUX_CTRL_LOCK_EN
    .lock_i      (lock),
`endif
    .req_valid_i (req_valid),
    .req_sel_i   (req_sel),
    .req_ready_o (req_ready),
    .sel_o       (sel),
    .busy_o      (busy),
    .done_o      (done),
    .dbg_state_o (dbg_state)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  // One request at edge T, then observe cycles T+1 .. T+12.
  task automatic run_switch(input logic want, input logic exp_sel, input string tag);
    int ndone = 0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL %s_pre_ready got=%b exp=1", tag, req_ready); end
    req_valid = 1'b1;
    req_sel   = want;
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = ~want;
    for (int i = 1; i <= 12; i++) begin
      total++; if (busy !== (i <= 9)) begin bad++; $display("FAIL %s_busy c=%0d got=%b exp=%b", tag, i, busy, (i <= 9)); end
      total++; if (done !== (i == 9)) begin bad++; $display("FAIL %s_done c=%0d got=%b exp=%b", tag, i, done, (i == 9)); end
      total++; if (req_ready !== (i >= 10)) begin bad++; $display("FAIL %s_ready c=%0d got=%b exp=%b", tag, i, req_ready, (i >= 10)); end
      total++; if (sel !== exp_sel) begin bad++; $display("FAIL %s_sel c=%0d got=%b exp=%b", tag, i, sel, exp_sel); end
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL %s_done_count got=%0d exp=1", tag, ndone); end
  endtask

  task automatic test_single();
    run_switch(1'b1, 1'b1, "single");
  endtask

  // sel_o starts at 1; held valid requests 0,1,0 accept at cycles 0,10,20.
  task automatic test_back_to_back();
    logic [2:0] seq = 3'b010;
    logic       exp_sel;
    for (int c = 0; c <= 30; c++) begin
      if (c == 0) exp_sel = 1'b1;
      else if (c <= 10) exp_sel = 1'b0;
      else if (c <= 20) exp_sel = 1'b1;
      else exp_sel = 1'b0;
      total++; if (sel !== exp_sel) begin bad++; $display("FAIL b2b_sel c=%0d got=%b exp=%b", c, sel, exp_sel); end
      total++; if (req_ready !== (c % 10 == 0)) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, (c % 10 == 0)); end
      total++; if (busy !== (c % 10 != 0)) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, (c % 10 != 0)); end
      total++; if (done !== (c % 10 == 9)) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, (c % 10 == 9)); end
      if (c == 30) begin
        req_valid = 1'b0;
      end else if (c % 10 == 0) begin
        req_valid = 1'b1;
        req_sel   = seq[c / 10];
      end
      @(negedge clk);
    end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL b2b_final_sel got=%b exp=0", sel); end
  endtask

  // sel_o starts at 0; switch to 1, reset asserted in cycle T+4.
  task automatic test_reset_mid_settle();
    req_valid = 1'b1;
    req_sel   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL mid_sel_before got=%b exp=1", sel); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_rst got=%b exp=0", req_ready); end
    @(negedge clk);
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL mid_sel_after got=%b exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL mid_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done c=%0d got=%b exp=0", i, done); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready c=%0d got=%b exp=1", i, req_ready); end
    end
  endtask

  task automatic test_same_sel();
    run_switch(1'b0, 1'b0, "same");
  endtask

`ifdef CLK_MUX_CTRL_LOCK_EN
  task automatic test_lock();
    lock      = 1'b1;
    req_valid = 1'b1;
    req_sel   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lock_idle_ready c=%0d got=%b exp=0", i, req_ready); end
      total++; if (sel !== 1'b0) begin bad++; $display("FAIL lock_idle_sel c=%0d got=%b exp=0", i, sel); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock_idle_busy c=%0d got=%b exp=0", i, busy); end
    end
    lock = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 3) lock = 1'b1;
      total++; if (done !== (i == 9)) begin bad++; $display("FAIL lock_done c=%0d got=%b exp=%b", i, done, (i == 9)); end
      total++; if (busy !== (i <= 9)) begin bad++; $display("FAIL lock_busy c=%0d got=%b exp=%b", i, busy, (i <= 9)); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lock_ready c=%0d got=%b exp=0", i, req_ready); end
      total++; if (sel !== 1'b1) begin bad++; $display("FAIL lock_sel c=%0d got=%b exp=1", i, sel); end
      @(negedge clk);
    end
    lock = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lock_release_ready got=%b exp=1", req_ready); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 1'b0;
`ifdef CLK_MUX_CTRL_LOCK_EN
    lock      = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_settle();
    test_same_sel();
`ifdef CLK_MUX_CTRL_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
